// File: rtl/ibwt_decode.sv
// ibwt_decode: inverse Burrows-Wheeler transform.
//   Accepts the last column L of the sorted rotation matrix and the row index
//   of the original string, then reconstructs the string with an LF-mapping:
//   one rank pass over L (N cycles) followed by a backward walk (N cycles).
//
// Ports:
//   clk          rising-edge clock
//   rst          synchronous active-high reset
//   start        single-cycle request, sampled only while idle
//   data_in      L column, data_in[0] is row 0 of the sorted matrix
//   primary_idx  row holding the original string (>= N flags an error)
//   data_out     reconstructed string, data_out[0] is the first character
//   busy         high while decoding
//   done         one-cycle pulse when data_out is final or on error
//   err          set with done for a bad primary_idx, held until next start
module ibwt_decode #(
  parameter int N  = 4,
  parameter int W  = 8,
  parameter int IW = $clog2(N)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic [W-1:0]  data_in [0:N-1],
  input  logic [IW:0]   primary_idx,
  output logic [W-1:0]  data_out [0:N-1],
  output logic          busy,
  output logic          done,
  output logic          err
);

  typedef enum logic [1:0] {
    IDLE,
    RANK,
    WALK
  } state_t;

  localparam logic [IW:0]   N_IDX  = (IW+1)'(N);
  localparam logic [IW:0]   ONE_C  = (IW+1)'(1);
  localparam logic [IW-1:0] ONE_I  = IW'(1);
  localparam logic [IW-1:0] LAST   = IW'(N-1);

  state_t        state_q, state_d;
  logic [W-1:0]  l_q   [0:N-1];
  logic [W-1:0]  l_d   [0:N-1];
  logic [IW-1:0] lf_q  [0:N-1];
  logic [IW-1:0] lf_d  [0:N-1];
  logic [W-1:0]  out_q [0:N-1];
  logic [W-1:0]  out_d [0:N-1];
  logic [IW-1:0] p_q, p_d;
  logic [IW-1:0] i_q, i_d;
  logic [IW-1:0] k_q, k_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;
  logic          err_q, err_d;
  logic          err_pend_q, err_pend_d;
  logic [IW:0]   rank_cnt;

  // Rank of row i: symbols strictly smaller anywhere, plus equal symbols in
  // earlier rows (stable tie-break). The total is always < N.
  always_comb begin
    rank_cnt = '0;
    for (int unsigned j = 0; j < N; j++) begin
      if (l_q[j] < l_q[i_q]) begin
        rank_cnt = rank_cnt + ONE_C;
      end else if ((l_q[j] == l_q[i_q]) && (IW'(j) < i_q)) begin
        rank_cnt = rank_cnt + ONE_C;
      end
    end
  end

  always_comb begin
    state_d    = state_q;
    l_d        = l_q;
    lf_d       = lf_q;
    out_d      = out_q;
    p_d        = p_q;
    i_d        = i_q;
    k_d        = k_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    err_d      = err_q;
    err_pend_d = 1'b0;

    case (state_q)
      IDLE: begin
        // A rejected index raises err immediately and pulses done one cycle
        // later; a start arriving in that gap is not taken.
        if (err_pend_q) begin
          done_d = 1'b1;
        end else if (start) begin
          l_d = data_in;
          p_d = primary_idx[IW-1:0];
          if (primary_idx >= N_IDX) begin
            err_d      = 1'b1;
            err_pend_d = 1'b1;
          end else begin
            err_d   = 1'b0;
            i_d     = '0;
            busy_d  = 1'b1;
            state_d = RANK;
          end
        end
      end

      RANK: begin
        lf_d[i_q] = rank_cnt[IW-1:0];
        if (i_q == LAST) begin
          k_d     = LAST;
          state_d = WALK;
        end else begin
          i_d = i_q + ONE_I;
        end
      end

      WALK: begin
        out_d[k_q] = l_q[p_q];
        p_d        = lf_q[p_q];
        if (k_q == '0) begin
          busy_d  = 1'b0;
          done_d  = 1'b1;
          state_d = IDLE;
        end else begin
          k_d = k_q - ONE_I;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      l_q        <= '{default: '0};
      lf_q       <= '{default: '0};
      out_q      <= '{default: '0};
      p_q        <= '0;
      i_q        <= '0;
      k_q        <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
      err_pend_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      l_q        <= l_d;
      lf_q       <= lf_d;
      out_q      <= out_d;
      p_q        <= p_d;
      i_q        <= i_d;
      k_q        <= k_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      err_q      <= err_d;
      err_pend_q <= err_pend_d;
    end
  end

  assign data_out = out_q;
  assign busy     = busy_q;
  assign done     = done_q;
  assign err      = err_q;

endmodule

// File: tb/tb_ibwt_decode.sv
// Directed testbench for ibwt_decode (N=4, W=8). Strings are written as
// 32-bit literals whose most significant byte is element 0.
module tb_ibwt_decode;

  localparam int N = 4;
  localparam int W = 8;

  logic         clk;
  logic         rst;
  logic         start;
  logic [W-1:0] din  [0:N-1];
  logic [2:0]   pidx;
  logic [W-1:0] dout [0:N-1];
  logic         busy;
  logic         done;
  logic         err;

  int total;
  int bad;

  ibwt_decode #(.N(N), .W(W)) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .data_in     (din),
    .primary_idx (pidx),
    .data_out    (dout),
    .busy        (busy),
    .done        (done),
    .err         (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic set_in(input logic [31:0] s, input logic [2:0] p);
    for (int i = 0; i < N; i++) din[i] = s[31-8*i -: 8];
    pidx = p;
  endtask

  function automatic logic [31:0] out_word();
    logic [31:0] r;
    for (int i = 0; i < N; i++) r[31-8*i -: 8] = dout[i];
    return r;
  endfunction

  // Caller has already raised start with the inputs set. Steps over the
  // accepting edge, then waits (bounded) for done. If poke_at >= 0, a second
  // start with other data is pulsed that many edges into the decode.
  task automatic run_decode(input string tag, input logic [31:0] exp_out, input int poke_at);
    int lat;
    int nb;
    step();
    start = 1'b0;
    nb  = busy ? 1 : 0;
    lat = 0;
    while (!done && lat < 20) begin
      step();
      lat++;
      start = 1'b0;
      if (lat == poke_at) begin
        set_in("abcd", 3'd1);
        start = 1'b1;
      end
      if (busy) nb++;
    end
    chk({tag, "_latency"}, lat, 2*N);
    chk({tag, "_busy_cycles"}, nb, 2*N);
    chk({tag, "_busy_at_done"}, {31'd0, busy}, 32'd0);
    chk({tag, "_data"}, out_word(), exp_out);
    chk({tag, "_err"}, {31'd0, err}, 32'd0);
  endtask

  initial begin
    total = 0;
    bad   = 0;
    rst   = 1'b1;
    start = 1'b0;
    set_in(32'd0, 3'd0);
    step();
    step();
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_err",  {31'd0, err},  32'd0);
    chk("rst_data", out_word(), 32'd0);
    rst = 1'b0;
    step();

    // Round trip 1: L="cdba", idx 2 -> "cadb"
    set_in("cdba", 3'd2);
    start = 1'b1;
    run_decode("rt1", "cadb", -1);
    step();
    chk("rt1_done_pulse", {31'd0, done}, 32'd0);

    // Round trip 2: repeated symbols, LF = 3,2,0,1
    set_in("cbaa", 3'd2);
    start = 1'b1;
    run_decode("rt2", "baca", -1);
    step();

    // Error path: index 4 is out of range
    set_in("dddd", 3'd4);
    start = 1'b1;
    step();
    start = 1'b0;
    chk("err_e0_done", {31'd0, done}, 32'd0);
    chk("err_e0_busy", {31'd0, busy}, 32'd0);
    step();
    chk("err_e1_done", {31'd0, done}, 32'd1);
    chk("err_e1_err",  {31'd0, err},  32'd1);
    chk("err_e1_busy", {31'd0, busy}, 32'd0);
    chk("err_keep_data", out_word(), "baca");
    step();
    chk("err_e2_done", {31'd0, done}, 32'd0);
    chk("err_held",    {31'd0, err},  32'd1);
    chk("err_e2_busy", {31'd0, busy}, 32'd0);

    // Degenerate all-equal string, two different primary rows
    set_in("aaaa", 3'd0);
    start = 1'b1;
    run_decode("deg0", "aaaa", -1);
    step();
    set_in("aaaa", 3'd3);
    start = 1'b1;
    run_decode("deg3", "aaaa", -1);
    step();

    // Start while busy (mid-WALK) is ignored
    set_in("cdba", 3'd2);
    start = 1'b1;
    run_decode("busy_start", "cadb", 6);
    // Start in the done cycle is accepted
    set_in("cbaa", 3'd2);
    start = 1'b1;
    run_decode("done_start", "baca", -1);
    step();

    // Reset during RANK
    set_in("cdba", 3'd2);
    start = 1'b1;
    step();
    start = 1'b0;
    step();
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("mid_rst_busy", {31'd0, busy}, 32'd0);
    chk("mid_rst_done", {31'd0, done}, 32'd0);
    chk("mid_rst_data", out_word(), 32'd0);
    step();
    chk("mid_rst_idle", {31'd0, busy}, 32'd0);
    set_in("cdba", 3'd2);
    start = 1'b1;
    run_decode("post_rst", "cadb", -1);
    step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/ibwt_decode.md
# ibwt_decode

- Inverse Burrows-Wheeler transform (decoder).
- Takes the last column L of the sorted rotation matrix, plus the primary index, and reconstructs the original N-symbol string.
- It is the receive-side counterpart of the forward BWT/merge-sort path: a string encoded by the forward path decodes back to the original input.
- Uses LF-mapping: one rank pass over L, then a backward walk.

## Interface
Parameters:
- N, 4, string length in symbols (≥2).
- W, 8, symbol width in bits.
- IW, $clog2(N), index width (derived; do not override).

Ports:
- clk  input  1  rising-edge clock; the only clock.
- rst  input  1  synchronous, active-high reset.
- start  input  1  single-cycle request; sampled only in IDLE.
- data_in [0:N-1]  input  W each  L column; data_in[0] is row 0 of the sorted matrix.
- primary_idx  input  IW+1  row of the sorted matrix holding the original string.
- data_out [0:N-1]  output  W each  reconstructed string; data_out[0] is the first character.
- busy  output  1  high while decoding.
- done  output  1  one-cycle pulse: data_out valid, or error.
- err  output  1  high with done when primary_idx ≥ N; held until the next accepted start or reset.

## Operation
- States: IDLE, RANK, WALK.
- **IDLE**
  - On start=1, latch data_in into L[] and primary_idx into p.
  - If primary_idx ≥ N: set err=1, pulse done next cycle, stay IDLE, leave data_out unchanged.
  - Otherwise: clear err, set i=0, go to RANK.
- **RANK** (N cycles, one row per cycle)
  - LF[i] = (count of j in 0..N-1 with L[j] < L[i]) + (count of j < i with L[j] == L[i]).
  - Comparisons are unsigned on W bits.
  - The sum is always < N, so store it truncated to IW bits.
  - After i=N-1, set k=N-1 and go to WALK.
- **WALK** (N cycles)
  - Each cycle: out_reg[k] ← L[p]; p ← LF[p]; k ← k-1.
  - After the k=0 write: go to IDLE, pulse done, drop busy.
  - data_out drives out_reg directly. Intermediate values are visible during WALK and are only guaranteed valid when done=1. They hold until overwritten by the next decode.
- start while busy is ignored; the current decode is not disturbed.
- start in the same cycle as done (back in IDLE) is accepted.
- Ties between equal symbols follow the stable rule above. The primary index for an all-equal string may be any row; every row gives the same output.
- Reset, at any time including mid-RANK/WALK: state=IDLE; busy=0, done=0, err=0; data_out all zero; LF, L, p, i, k cleared. The partial result is discarded.

## Timing
- Edge E0 samples start=1 in IDLE.
- busy rises after E0.
- RANK occupies edges E1..EN.
- WALK occupies edges EN+1..E2N.
- After E2N: done=1 for exactly one cycle, busy=0, data_out final.
- Latency from start to done is 2N cycles (8 for N=4).
- Error path: done=1 and err=1 after E1; busy never asserts.
- Reset values: busy=0, done=0, err=0, data_out all 0.
- No combinational path from inputs to outputs; all outputs are registered.

## Test plan
- **Encode round-trip 1.** data_in="cdba", primary_idx=2, pulse start → after 8 cycles done=1, data_out="cadb", err=0, busy was high for exactly 8 cycles.
- **Encode round-trip 2.** data_in="cbaa", primary_idx=2 → data_out="baca"; checks the repeated-symbol occ term (LF = 3,2,0,1).
- **Degenerate input.** data_in="aaaa", primary_idx=0 and then 3 → data_out="aaaa" both times.
- **Error path.** primary_idx=4 → done and err high one cycle after start, busy stays 0, data_out keeps the previous "baca".
- **Start handling.** Pulse start again mid-WALK with different data → ignored, result is the first string. Then assert start in the done cycle → second decode accepted, done 8 cycles later.
- **Reset mid-operation.** Assert rst at RANK cycle 2 → next cycle busy=0, done=0, data_out=0. A fresh start with "cdba"/2 then decodes "cadb" normally.
